// File: rtl/control_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : control_multi_if
// Purpose  : Bundles the per-player button and direction signals and the
//            engine strobes that pass between the input pins/game engine and
//            control_multi.
// Modports : master - drives buttons, current directions, tick and clear;
//                     observes the queued direction, pending, overflow, start
//            slave  - the control_multi side (the opposite directions)
// Signals  : i_up/i_down/i_left/i_right [PLAYERS]  raw buttons, bit p = player p
//            i_dir   [2*PLAYERS]  current snake directions, bits [2p+1:2p]
//            i_tick               game step strobe
//            i_clear              flush all turn queues
//            o_dir   [2*PLAYERS]  direction to apply at the next tick
//            o_pending [PLAYERS]  queue of player p non-empty
//            o_overflow[PLAYERS]  valid press dropped because the queue was full
//            o_start              sticky game-start flag
// Revision : 1.0 - initial release
// ============================================================================
interface control_multi_if #(
    parameter int PLAYERS = 2
);
    logic [PLAYERS-1:0]   i_up;
    logic [PLAYERS-1:0]   i_down;
    logic [PLAYERS-1:0]   i_left;
    logic [PLAYERS-1:0]   i_right;
    logic [2*PLAYERS-1:0] i_dir;
    logic                 i_tick;
    logic                 i_clear;
    logic [2*PLAYERS-1:0] o_dir;
    logic [PLAYERS-1:0]   o_pending;
    logic [PLAYERS-1:0]   o_overflow;
    logic                 o_start;

    modport master (
        output i_up, i_down, i_left, i_right, i_dir, i_tick, i_clear,
        input  o_dir, o_pending, o_overflow, o_start
    );

    modport slave (
        input  i_up, i_down, i_left, i_right, i_dir, i_tick, i_clear,
        output o_dir, o_pending, o_overflow, o_start
    );
endinterface
`default_nettype wire

// File: rtl/control_multi.sv
`default_nettype none
// ============================================================================
// Module   : control_multi
// Purpose  : Multi-player direction control. Each player's button presses are
//            edge-detected, checked against the direction at the tail of that
//            player's turn queue and buffered (up to QUEUE_DEPTH turns). The
//            game engine pops one turn per player on every i_tick. Also
//            produces the sticky game-start flag.
// Ports    : clk  - system clock
//            rst  - synchronous, active-high reset
//            bus  - control_multi_if.slave (buttons, i_dir, i_tick, i_clear,
//                   o_dir, o_pending, o_overflow, o_start)
// Options  : CONTROL_DEBOUNCE_EN - when defined, each button passes through a
//            saturating debounce counter (DEBOUNCE_CYCLES stable-high cycles)
//            before edge detection.
// Encoding : direction 00 up, 01 down, 10 left, 11 right (bit1 = horizontal);
//            button vectors are {right,left,down,up}, so a button's bit index
//            equals its direction code.
// Revision : 1.0 - initial release
// ============================================================================
module control_multi #(
    parameter int         PLAYERS         = 2,
    parameter int         QUEUE_DEPTH     = 4,
    parameter logic [3:0] START_MASK      = 4'b1101,
    parameter int         DEBOUNCE_CYCLES = 1024
) (
    input  wire logic        clk,
    input  wire logic        rst,
    control_multi_if.slave   bus
);

    localparam int                c_ptr_w = $clog2(QUEUE_DEPTH);
    localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(QUEUE_DEPTH);

    logic [PLAYERS-1:0] w_start_hit;
    logic               start_q;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [3:0]         w_raw;
        logic [3:0]         w_level;
        logic [3:0]         hist_q;
        logic [3:0]         w_press;
        logic               w_sel_valid;
        logic [1:0]         w_sel_dir;
        logic [1:0]         w_cur_dir;
        logic [1:0]         w_tail;
        logic               w_accept;
        logic               w_full;
        logic               w_pop;
        logic               w_push;
        logic               w_drop;
        logic [1:0]         mem_q [QUEUE_DEPTH];
        logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
        logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
        logic [c_ptr_w:0]   count_q, count_d;
        logic               ovf_q;

        assign w_raw = {bus.i_right[p], bus.i_left[p], bus.i_down[p], bus.i_up[p]};

`ifdef CONTROL_DEBOUNCE_EN
        localparam int              c_db_w   = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [c_db_w-1:0] c_db_max = c_db_w'(DEBOUNCE_CYCLES);

        for (genvar b = 0; b < 4; b++) begin : g_debounce
            logic [c_db_w-1:0] cnt_q;
            logic              filt_q;

            // Filtered level starts high so a button held through reset
            // never looks like a fresh press.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else if (!w_raw[b]) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else if (cnt_q != c_db_max) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == c_db_max - 1'b1) begin
                        filt_q <= 1'b1;
                    end
                end
            end

            assign w_level[b] = filt_q;
        end
`else
        assign w_level = w_raw;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                hist_q <= 4'hF;
            end else begin
                hist_q <= w_level;
            end
        end

        assign w_press = w_level & ~hist_q;

        // Priority up > down > left > right; bit index doubles as the code.
        always_comb begin
            w_sel_valid = |w_press;
            w_sel_dir   = 2'b00;
            if (w_press[0]) begin
                w_sel_dir = 2'b00;
            end else if (w_press[1]) begin
                w_sel_dir = 2'b01;
            end else if (w_press[2]) begin
                w_sel_dir = 2'b10;
            end else if (w_press[3]) begin
                w_sel_dir = 2'b11;
            end
        end

        assign w_cur_dir = bus.i_dir[2*p +: 2];
        // Tail is taken from the pre-pop queue contents.
        assign w_tail    = (count_q != '0) ? mem_q[wr_ptr_q - 1'b1] : w_cur_dir;
        assign w_accept  = w_sel_valid && (w_sel_dir[1] != w_tail[1]);
        assign w_full    = (count_q == c_depth);
        assign w_pop     = bus.i_tick && (count_q != '0);
        // A simultaneous pop frees the slot a full queue needs.
        assign w_push    = w_accept && !bus.i_clear && (!w_full || w_pop);
        assign w_drop    = w_accept && !bus.i_clear && w_full && !w_pop;

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (bus.i_clear) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (w_push) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (w_pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                count_d = count_q + {{c_ptr_w{1'b0}}, w_push}
                                  - {{c_ptr_w{1'b0}}, w_pop};
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                ovf_q    <= w_drop;
            end
        end

        // Storage needs no reset: entries are only read when count_q covers them.
        always_ff @(posedge clk) begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= w_sel_dir;
            end
        end

        assign bus.o_dir[2*p +: 2] = (count_q != '0) ? mem_q[rd_ptr_q] : w_cur_dir;
        assign bus.o_pending[p]    = (count_q != '0);
        assign bus.o_overflow[p]   = ovf_q;
        // Any masked press counts, whether or not the turn is valid.
        assign w_start_hit[p]      = |(w_press & START_MASK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
        end else if (|w_start_hit) begin
            start_q <= 1'b1;
        end
    end

    assign bus.o_start = start_q;

endmodule
`default_nettype wire
